// File: rtl/eeg_aram_bank_rsp.sv
// eeg_aram_bank_rsp: bank-end responder of the ARAM address/data protocol.
// Sits between the router's AARB_* read channel and one activation SRAM bank
// (single-port, 1-cycle read latency). The loader write port shares the SRAM
// and always wins over reads. Read data returns in order, tagged with the LST
// bit of its address, through a small output FIFO protected by read credits.
module eeg_aram_bank_rsp #(
  parameter int ARAM_ADD_AW = 12,
  parameter int ARAM_DAT_DW = 4,
  parameter int RSP_BUF_AW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // loader write port
  input  logic                   ARAM_WR_VLD,
  output logic                   ARAM_WR_RDY,
  input  logic [ARAM_ADD_AW-1:0] ARAM_WR_ADD,
  input  logic [ARAM_DAT_DW-1:0] ARAM_WR_DAT,
  // read address channel
  input  logic                   AARB_ADD_VLD,
  input  logic                   AARB_ADD_LST,
  output logic                   AARB_ADD_RDY,
  input  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD,
  // read data channel
  output logic                   AARB_DAT_VLD,
  output logic                   AARB_DAT_LST,
  input  logic                   AARB_DAT_RDY,
  output logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT,
  // SRAM macro side
  output logic                   SRAM_CEN,
  output logic                   SRAM_WEN,
  output logic [ARAM_ADD_AW-1:0] SRAM_ADD,
  output logic [ARAM_DAT_DW-1:0] SRAM_DIN,
  input  logic [ARAM_DAT_DW-1:0] SRAM_DOUT,
  // outstanding reads (in flight + buffered)
  output logic [RSP_BUF_AW:0]    RSP_OCC
);

  localparam int DEPTH = 1 << RSP_BUF_AW;
  localparam int OW    = RSP_BUF_AW + 1;

  // one buffered response word: LST tag plus data
  typedef struct packed {
    logic                   lst;
    logic [ARAM_DAT_DW-1:0] dat;
  } rsp_t;

  logic                  alive_q;
  logic                  inflight_q;
  logic                  lst_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic [OW-1:0]         cnt_q, cnt_d;
  logic [RSP_BUF_AW-1:0] wptr_q, wptr_d;
  logic [RSP_BUF_AW-1:0] rptr_q, rptr_d;
  rsp_t                  mem_q [DEPTH];
  rsp_t                  head;

  logic wr_ena, add_rdy, add_ena, push, pop, fifo_empty, fifo_full;

  // alive_q drops asynchronously with reset, so both ready outputs and the
  // SRAM enables fall to their idle values the moment rst_n goes low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  assign ARAM_WR_RDY = alive_q;
  assign wr_ena      = ARAM_WR_VLD & alive_q;

  // Read credit comes only from registered occupancy: a pop this cycle frees
  // its slot next cycle, which keeps ADD_RDY off the DAT_RDY combinational path.
  // A write request steals the single SRAM port, so it blocks the read.
  assign add_rdy      = alive_q & ~ARAM_WR_VLD & (occ_q < OW'(DEPTH));
  assign add_ena      = AARB_ADD_VLD & add_rdy;
  assign AARB_ADD_RDY = add_rdy;

  // SRAM port mux: write has priority, otherwise an accepted read, else idle
  always_comb begin
    SRAM_CEN = 1'b1;
    SRAM_WEN = 1'b1;
    SRAM_ADD = AARB_ADD_ADD;
    SRAM_DIN = ARAM_WR_DAT;
    if (wr_ena) begin
      SRAM_CEN = 1'b0;
      SRAM_WEN = 1'b0;
      SRAM_ADD = ARAM_WR_ADD;
    end else if (add_ena) begin
      SRAM_CEN = 1'b0;
    end
  end

  // track the read whose data comes out of the SRAM next cycle, with its LST tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      lst_q      <= 1'b0;
    end else begin
      inflight_q <= add_ena;
      if (add_ena) lst_q <= AARB_ADD_LST;
    end
  end

  // FIFO status and handshakes; SRAM output is captured only, never bypassed
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == OW'(DEPTH));
  assign push       = inflight_q;
  assign pop        = ~fifo_empty & AARB_DAT_RDY;
  assign head       = mem_q[rptr_q];

  assign AARB_DAT_VLD = ~fifo_empty;
  assign AARB_DAT_DAT = fifo_empty ? '0   : head.dat;
  assign AARB_DAT_LST = fifo_empty ? 1'b0 : head.lst;

  // next-state for pointers, fill count and read credit counter
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;   // power-of-two depth: natural wrap
    if (pop)  rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + OW'(push) - OW'(pop);
    occ_d = occ_q + OW'(add_ena) - OW'(pop);
  end

  // pointer / counter registers; reset discards everything in flight or buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
    end
  end

  // FIFO storage; contents need no reset since the count masks stale entries
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{lst: lst_q, dat: SRAM_DOUT};
  end

  assign RSP_OCC = occ_q;

  // credit must make an overflowing push impossible, and the credit counter
  // must always equal the in-flight read plus buffered words
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && fifo_full && !pop));
      assert (occ_q == cnt_q + OW'(inflight_q));
    end
  end

endmodule

// File: tb/tb_eeg_aram_bank_rsp.sv
// Bench for eeg_aram_bank_rsp: SRAM behavioural model, directed bursts and a
// randomized phase; expected words queued at address handshake, checked by
// an independent monitor on the data channel.
module tb_eeg_aram_bank_rsp;
  localparam int AW = 12;
  localparam int DW = 4;
  localparam int BAW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ARAM_WR_VLD = 0, ARAM_WR_RDY;
  logic [AW-1:0] ARAM_WR_ADD = '0;
  logic [DW-1:0] ARAM_WR_DAT = '0;
  logic          AARB_ADD_VLD = 0, AARB_ADD_LST = 0, AARB_ADD_RDY;
  logic [AW-1:0] AARB_ADD_ADD = '0;
  logic          AARB_DAT_VLD, AARB_DAT_LST, AARB_DAT_RDY = 0;
  logic [DW-1:0] AARB_DAT_DAT;
  logic          SRAM_CEN, SRAM_WEN;
  logic [AW-1:0] SRAM_ADD;
  logic [DW-1:0] SRAM_DIN, SRAM_DOUT;
  logic [BAW:0]  RSP_OCC;

  eeg_aram_bank_rsp #(.ARAM_ADD_AW(AW), .ARAM_DAT_DW(DW), .RSP_BUF_AW(BAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ARAM_WR_VLD(ARAM_WR_VLD), .ARAM_WR_RDY(ARAM_WR_RDY),
    .ARAM_WR_ADD(ARAM_WR_ADD), .ARAM_WR_DAT(ARAM_WR_DAT),
    .AARB_ADD_VLD(AARB_ADD_VLD), .AARB_ADD_LST(AARB_ADD_LST),
    .AARB_ADD_RDY(AARB_ADD_RDY), .AARB_ADD_ADD(AARB_ADD_ADD),
    .AARB_DAT_VLD(AARB_DAT_VLD), .AARB_DAT_LST(AARB_DAT_LST),
    .AARB_DAT_RDY(AARB_DAT_RDY), .AARB_DAT_DAT(AARB_DAT_DAT),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_ADD(SRAM_ADD),
    .SRAM_DIN(SRAM_DIN), .SRAM_DOUT(SRAM_DOUT), .RSP_OCC(RSP_OCC)
  );

  // single-port SRAM with 1-cycle read latency
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!SRAM_CEN) begin
      if (!SRAM_WEN) sram[SRAM_ADD] <= SRAM_DIN;
      else           SRAM_DOUT <= sram[SRAM_ADD];
    end
  end

  // reference model: memory contents as the loader wrote them + expected queue
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q [$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int hs_cnt = 0, lst_sent = 0, n_recv = 0, lst_recv = 0;
  int first_hs = -1, last_hs = -1, first_vld = -1, last_vld = -1, wr_cyc = -1;
  bit rdy_rand = 0;
  bit burst_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every data handshake must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && AARB_DAT_VLD && AARB_DAT_RDY) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word got dat=%0h lst=%0b expected none", AARB_DAT_DAT, AARB_DAT_LST);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("rd_dat", 32'(AARB_DAT_DAT), 32'(e[DW-1:0]));
        chk("rd_lst", 32'(AARB_DAT_LST), 32'(e[DW]));
      end
      n_recv++;
      if (AARB_DAT_LST) lst_recv++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
  end

  // random downstream backpressure when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) AARB_DAT_RDY = 1'($urandom % 2);
  end

  // tasks start and end at posedge+1
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic r;
    r = 0;
    ARAM_WR_VLD = 1; ARAM_WR_ADD = a; ARAM_WR_DAT = d;
    for (int i = 0; i < 20 && !r; i++) begin
      @(negedge clk); r = ARAM_WR_RDY; if (r) wr_cyc = cyc;
      @(posedge clk); #1;
      if (r) begin ref_mem[a] = d; sram_note(); end
    end
    ARAM_WR_VLD = 0;
    if (!r) chk("wr_timeout", 0, 1);
  endtask

  function automatic void sram_note();
  endfunction

  task automatic rd(input logic [AW-1:0] a, input logic l);
    logic r;
    int hc;
    r = 0;
    AARB_ADD_VLD = 1; AARB_ADD_ADD = a; AARB_ADD_LST = l;
    for (int i = 0; i < 300 && !r; i++) begin
      @(negedge clk); r = AARB_ADD_RDY; hc = cyc;
      @(posedge clk); #1;
      if (r) begin
        exp_q.push_back({l, ref_mem[a]});
        hs_cnt++;
        if (l) lst_sent++;
        if (first_hs < 0) first_hs = hc;
        last_hs = hc;
      end
    end
    AARB_ADD_VLD = 0;
    if (!r) chk("rd_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_wr_rdy"},  32'(ARAM_WR_RDY), 0);
    chk({p, "_add_rdy"}, 32'(AARB_ADD_RDY), 0);
    chk({p, "_dat_vld"}, 32'(AARB_DAT_VLD), 0);
    chk({p, "_dat_lst"}, 32'(AARB_DAT_LST), 0);
    chk({p, "_dat_dat"}, 32'(AARB_DAT_DAT), 0);
    chk({p, "_cen"},     32'(SRAM_CEN), 1);
    chk({p, "_wen"},     32'(SRAM_WEN), 1);
    chk({p, "_occ"},     32'(RSP_OCC), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lbase, sbase, rc;
    for (int i = 0; i < (1<<AW); i++) begin sram[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // directed burst, full rate
    AARB_DAT_RDY = 1;
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(3 + i));
    first_hs = -1; first_vld = -1; base = n_recv; lbase = lst_recv;
    for (int i = 0; i < 8; i++) rd(AW'(i), i == 7);
    drain();
    chk("b1_latency", 32'(first_vld - first_hs), 2);
    chk("b1_rate", 32'(last_vld - first_vld), 7);
    chk("b1_count", 32'(n_recv - base), 8);
    chk("b1_lst_cnt", 32'(lst_recv - lbase), 1);

    // backpressured burst: credit limits to DEPTH outstanding
    AARB_DAT_RDY = 0; base = hs_cnt; burst_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) rd(AW'(i), i == 7);
        burst_done = 1;
      end
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("b2_hs_cnt", 32'(hs_cnt - base), 4);
    chk("b2_add_rdy", 32'(AARB_ADD_RDY), 0);
    chk("b2_occ", 32'(RSP_OCC), 4);
    @(posedge clk); #1; AARB_DAT_RDY = 1;
    @(negedge clk); chk("b2_rdy_pop_cyc", 32'(AARB_ADD_RDY), 0);
    @(negedge clk); chk("b2_rdy_after_pop", 32'(AARB_ADD_RDY), 1);
    for (int i = 0; i < 100 && !burst_done; i++) @(posedge clk);
    chk("b2_burst_done", 32'(burst_done), 1);
    @(posedge clk); #1;
    drain();

    // write and read collide on addr 5: write first, read next cycle
    fork
      wr(AW'(5), 4'hC);
      rd(AW'(5), 1'b1);
    join
    chk("wr_rd_order", 32'(last_hs - wr_cyc), 1);
    chk("wr_rd_refmem", 32'(ref_mem[5]), 32'hC);
    drain();

    // randomized traffic with interleaved writes and 50% backpressure
    for (int i = 0; i < 64; i++) wr(AW'(i), DW'($urandom));
    base = n_recv; lbase = lst_recv; sbase = lst_sent;
    rdy_rand = 1;
    for (int i = 0; i < 256; i++) begin
      if ($urandom % 8 == 0) wr(AW'($urandom % 64), DW'($urandom));
      rd(AW'($urandom % 64), ($urandom % 4) == 0);
    end
    rdy_rand = 0;
    @(posedge clk); #1; AARB_DAT_RDY = 1;
    drain();
    chk("rnd_count", 32'(n_recv - base), 256);
    chk("rnd_lst_cnt", 32'(lst_recv - lbase), 32'(lst_sent - sbase));

    // reset with 3 words buffered and 1 read in flight
    AARB_DAT_RDY = 0;
    for (int i = 0; i < 4; i++) rd(AW'(i), 1'b0);
    chk("pre_rst_occ", 32'(RSP_OCC), 4);
    #2 rst_n = 0;
    #1 chk_reset("rst1");
    exp_q.delete();
    AARB_DAT_RDY = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    rc = n_recv;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_recv", 32'(n_recv - rc), 0);
    chk("post_rst_occ", 32'(RSP_OCC), 0);
    chk("post_rst_vld", 32'(AARB_DAT_VLD), 0);
    chk("post_rst_add_rdy", 32'(AARB_ADD_RDY), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
